// File: rtl/i2s_tx_ctrl.sv
// Purpose: I2S master timing (SCLK/LRCK) plus one-entry staging of stereo pairs for the transmitter.
// Latency: a staged pair reaches pldata/prdata at the next update point (SCLK fall at count W+UPD_OFFSET).
// Backpressure: s_ready_out is registered and low while the staging register holds an unconsumed pair.
module i2s_tx_ctrl #(
    parameter int PDATA_WIDTH = 32,
    parameter int SCLK_DIV    = 4,
    parameter int UPD_OFFSET  = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   en_in,
    input  logic                   s_valid_in,
    output logic                   s_ready_out,
    input  logic [PDATA_WIDTH-1:0] s_ldata_in,
    input  logic [PDATA_WIDTH-1:0] s_rdata_in,
    output logic                   sclk_out,
    output logic                   lrck_out,
    output logic [PDATA_WIDTH-1:0] pldata_out,
    output logic [PDATA_WIDTH-1:0] prdata_out,
    output logic                   frame_start_out,
    output logic                   underrun_out,
    output logic [15:0]            underrun_cnt_out
);

    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * PDATA_WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * PDATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] RSLOT    = BIT_W'(PDATA_WIDTH);
    localparam logic [BIT_W-1:0] UPD_CNT  = BIT_W'(PDATA_WIDTH + UPD_OFFSET);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [BIT_W-1:0]       bit_cnt_nxt;
    logic                   sclk_q, sclk_d;
    logic                   lrck_q, lrck_d;
    logic                   fall;

    logic                   stg_full_q, stg_full_d;
    logic [PDATA_WIDTH-1:0] stg_l_q, stg_l_d;
    logic [PDATA_WIDTH-1:0] stg_r_q, stg_r_d;
    logic [PDATA_WIDTH-1:0] pl_q, pl_d;
    logic [PDATA_WIDTH-1:0] pr_q, pr_d;
    logic                   rdy_q, rdy_d;
    logic                   fs_q, fs_d;
    logic                   ur_q, ur_d;
    logic [15:0]            ucnt_q, ucnt_d;
    logic                   upd;
    logic                   accept;

    // FSM next state plus divider, SCLK/LRCK and bit counter; leaving RUN clears the timing immediately
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        sclk_d      = sclk_q;
        lrck_d      = lrck_q;
        fall        = 1'b0;
        bit_cnt_nxt = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                sclk_d    = 1'b0;
                lrck_d    = 1'b0;
                if (en_in) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en_in) begin
                    state_d   = ST_IDLE;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    sclk_d    = 1'b0;
                    lrck_d    = 1'b0;
                end else if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    sclk_d    = ~sclk_q;
                    // A toggle from high is a fall: LRCK and the bit count only move here
                    if (sclk_q) begin
                        fall      = 1'b1;
                        bit_cnt_d = bit_cnt_nxt;
                        lrck_d    = (bit_cnt_nxt >= RSLOT);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Staging handshake, safe-point word update and underrun accounting
    always_comb begin
        stg_full_d = stg_full_q;
        stg_l_d    = stg_l_q;
        stg_r_d    = stg_r_q;
        pl_d       = pl_q;
        pr_d       = pr_q;
        ucnt_d     = ucnt_q;
        ur_d       = 1'b0;
        upd        = fall && (bit_cnt_nxt == UPD_CNT);
        fs_d       = fall && (bit_cnt_nxt == '0);
        accept     = s_valid_in && rdy_q;
        if (upd) begin
            if (stg_full_q) begin
                pl_d       = stg_l_q;
                pr_d       = stg_r_q;
                stg_full_d = 1'b0;
            end else begin
                pl_d = '0;
                pr_d = '0;
                ur_d = 1'b1;
                if (ucnt_q != 16'hFFFF) begin
                    ucnt_d = ucnt_q + 16'd1;
                end
            end
        end
        // accept implies staging was empty, so it never collides with a drain; a same-clk
        // accept lands in staging for the next frame rather than bypassing to the outputs
        if (accept) begin
            stg_full_d = 1'b1;
            stg_l_d    = s_ldata_in;
            stg_r_d    = s_rdata_in;
        end
        rdy_d = ~stg_full_d;
    end

    // State and datapath registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            lrck_q     <= 1'b0;
            stg_full_q <= 1'b0;
            stg_l_q    <= '0;
            stg_r_q    <= '0;
            pl_q       <= '0;
            pr_q       <= '0;
            rdy_q      <= 1'b0;
            fs_q       <= 1'b0;
            ur_q       <= 1'b0;
            ucnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= sclk_d;
            lrck_q     <= lrck_d;
            stg_full_q <= stg_full_d;
            stg_l_q    <= stg_l_d;
            stg_r_q    <= stg_r_d;
            pl_q       <= pl_d;
            pr_q       <= pr_d;
            rdy_q      <= rdy_d;
            fs_q       <= fs_d;
            ur_q       <= ur_d;
            ucnt_q     <= ucnt_d;
        end
    end

    assign s_ready_out      = rdy_q;
    assign sclk_out         = sclk_q;
    assign lrck_out         = lrck_q;
    assign pldata_out       = pl_q;
    assign prdata_out       = pr_q;
    assign frame_start_out  = fs_q;
    assign underrun_out     = ur_q;
    assign underrun_cnt_out = ucnt_q;

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Purpose: directed bench for i2s_tx_ctrl with a time-based reference model checked every cycle.
// Latency: model advances on each rising edge, outputs compared on the falling edge.
// Backpressure: stimulus only advances its sample counter when a pair is actually accepted.
module tb_i2s_tx_ctrl;

    localparam int W = 16;
    localparam int D = 2;
    localparam int U = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         sv = 1'b0;
    logic [W-1:0] sl = '0;
    logic [W-1:0] sr = '0;
    logic         rdy, sclk, lrck, fs, ur;
    logic [W-1:0] pl, pr;
    logic [15:0]  ucnt;

    int total = 0;
    int bad   = 0;
    int run_n = 0;
    bit streaming = 1'b0;

    i2s_tx_ctrl #(.PDATA_WIDTH(W), .SCLK_DIV(D), .UPD_OFFSET(U)) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .en_in            (en),
        .s_valid_in       (sv),
        .s_ready_out      (rdy),
        .s_ldata_in       (sl),
        .s_rdata_in       (sr),
        .sclk_out         (sclk),
        .lrck_out         (lrck),
        .pldata_out       (pl),
        .prdata_out       (pr),
        .frame_start_out  (fs),
        .underrun_out     (ur),
        .underrun_cnt_out (ucnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: timing derived from clks elapsed since entering RUN
    bit           m_run, m_full, m_rdy, m_fs, m_ur;
    int           n, m_ucnt;
    logic [W-1:0] m_sl, m_sr, m_pl, m_pr;

    task automatic mreset();
        m_run = 0; n = 0; m_full = 0; m_rdy = 0; m_fs = 0; m_ur = 0;
        m_ucnt = 0; m_sl = '0; m_sr = '0; m_pl = '0; m_pr = '0;
    endtask

    task automatic madvance();
        bit acc, upd;
        int f;
        acc  = sv && m_rdy;
        upd  = 0;
        m_fs = 0;
        m_ur = 0;
        if (!m_run) begin
            if (en) begin m_run = 1; n = 0; end
        end else if (!en) begin
            m_run = 0; n = 0;
        end else begin
            n++;
            if (n % (2 * D) == 0) begin
                f = (n / (2 * D)) % (2 * W);
                if (f == 0) m_fs = 1;
                if (f == W + U) upd = 1;
            end
        end
        if (upd) begin
            if (m_full) begin
                m_pl = m_sl; m_pr = m_sr; m_full = 0;
            end else begin
                m_pl = '0; m_pr = '0; m_ur = 1;
                if (m_ucnt < 65535) m_ucnt++;
            end
        end
        if (acc) begin
            m_full = 1; m_sl = sl; m_sr = sr;
        end
        m_rdy = !m_full;
    endtask

    // Compare process: every cycle, on the falling edge
    initial begin
        mreset();
        forever begin
            @(posedge clk);
            if (rst_n) madvance();
            @(negedge clk);
            if (!rst_n) mreset();
            chk("m_sclk", 32'(sclk), m_run ? 32'((n / D) % 2) : 32'd0);
            chk("m_lrck", 32'(lrck), (m_run && ((n / (2 * D)) % (2 * W)) >= W) ? 32'd1 : 32'd0);
            chk("m_ready", 32'(rdy), 32'(m_rdy));
            chk("m_fstart", 32'(fs), 32'(m_fs));
            chk("m_urun", 32'(ur), 32'(m_ur));
            chk("m_ucnt", 32'(ucnt), 32'(m_ucnt));
            chk("m_pl", 32'(pl), 32'(m_pl));
            chk("m_pr", 32'(pr), 32'(m_pr));
        end
    end

    // One clock of stimulus; advances the streamed pair only after an accept
    task automatic step();
        bit acc;
        @(negedge clk);
        acc = sv && rdy;
        @(posedge clk);
        #1;
        if (acc && streaming) begin
            sl = sl + 1'b1;
            sr = sr + 1'b1;
        end
        run_n++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    // Directed sequence with literal expectations
    initial begin
        repeat (5) @(posedge clk);
        #1;
        chk("rst_ready", 32'(rdy), 32'd0);
        chk("rst_pl", 32'(pl), 32'd0);
        rst_n = 1'b1;
        repeat (50) step();
        chk("idle_ready", 32'(rdy), 32'd1);
        chk("idle_sclk", 32'(sclk), 32'd0);

        // Prefill in IDLE, then stream incrementing pairs
        sl = 16'h1234; sr = 16'hABCD; sv = 1'b1; streaming = 1'b1;
        step();
        chk("prefill_ready", 32'(rdy), 32'd0);
        en = 1'b1;
        run_n = -1;
        for (int i = 0; i < 491; i++) begin
            step();
            if (run_n == 1)   chk("a_sclk1", 32'(sclk), 32'd0);
            if (run_n == 2)   chk("a_sclk2", 32'(sclk), 32'd1);
            if (run_n == 63)  chk("a_lrck63", 32'(lrck), 32'd0);
            if (run_n == 64)  chk("a_lrck64", 32'(lrck), 32'd1);
            if (run_n == 127) chk("a_fs127", 32'(fs), 32'd0);
            if (run_n == 128) chk("a_fs128", 32'(fs), 32'd1);
            if (run_n == 79)  chk("a_pl79", 32'(pl), 32'h0);
            if (run_n == 80)  chk("a_pl80", 32'(pl), 32'h1234);
            if (run_n == 80)  chk("a_pr80", 32'(pr), 32'hABCD);
            if (run_n == 80)  chk("a_rdy80", 32'(rdy), 32'd1);
            if (run_n == 81)  chk("a_rdy81", 32'(rdy), 32'd0);
            if (run_n == 207) chk("a_pl207", 32'(pl), 32'h1234);
            if (run_n == 208) chk("a_pl208", 32'(pl), 32'h1235);
            if (run_n == 336) chk("a_pr336", 32'(pr), 32'hABCF);
        end
        chk("a_sclk490", 32'(sclk), 32'd1);
        chk("a_lrck490", 32'(lrck), 32'd1);
        chk("a_ucnt", 32'(ucnt), 32'd0);

        // Disable mid right slot: timing clears, words held, staging kept
        en = 1'b0; sv = 1'b0; streaming = 1'b0;
        step();
        chk("dis_sclk", 32'(sclk), 32'd0);
        chk("dis_lrck", 32'(lrck), 32'd0);
        chk("dis_pl", 32'(pl), 32'h1237);
        repeat (20) step();
        chk("dis_pr_hold", 32'(pr), 32'hABD0);

        // Re-enable: restart from count 0, then underruns and a late single pair
        en = 1'b1;
        run_n = -1;
        for (int i = 0; i < 731; i++) begin
            step();
            if (run_n == 2)   chk("c_sclk2", 32'(sclk), 32'd1);
            if (run_n == 63)  chk("c_lrck63", 32'(lrck), 32'd0);
            if (run_n == 80)  chk("c_pl80", 32'(pl), 32'h1238);
            if (run_n == 80)  chk("c_pr80", 32'(pr), 32'hABD1);
            if (run_n == 208) chk("c_ur208", 32'(ur), 32'd1);
            if (run_n == 208) chk("c_ucnt208", 32'(ucnt), 32'd1);
            if (run_n == 208) chk("c_pl208", 32'(pl), 32'h0);
            if (run_n == 209) chk("c_ur209", 32'(ur), 32'd0);
            if (run_n == 250) begin sl = 16'h5555; sr = 16'hAAAA; sv = 1'b1; end
            if (run_n == 251) sv = 1'b0;
            if (run_n == 336) chk("c_pl336", 32'(pl), 32'h5555);
            if (run_n == 464) chk("c_ucnt464", 32'(ucnt), 32'd2);
            // Offer a pair only on the update clk itself
            if (run_n == 591) begin sl = 16'h0F0F; sr = 16'hF0F0; sv = 1'b1; end
            if (run_n == 592) begin
                sv = 1'b0;
                chk("d_ur592", 32'(ur), 32'd1);
                chk("d_ucnt592", 32'(ucnt), 32'd3);
                chk("d_pl592", 32'(pl), 32'h0);
                chk("d_rdy592", 32'(rdy), 32'd0);
            end
            if (run_n == 720) chk("d_pl720", 32'(pl), 32'h0F0F);
            if (run_n == 720) chk("d_pr720", 32'(pr), 32'hF0F0);
            if (run_n == 720) chk("d_ucnt720", 32'(ucnt), 32'd3);
        end
        chk("e_lrck_pre", 32'(lrck), 32'd1);

        // Asynchronous reset in the middle of a frame
        @(posedge clk);
        #3;
        en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("e_pl", 32'(pl), 32'd0);
        chk("e_ucnt", 32'(ucnt), 32'd0);
        chk("e_lrck", 32'(lrck), 32'd0);
        chk("e_rdy", 32'(rdy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) step();
        chk("e_rdy_after", 32'(rdy), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
